// File: rtl/len5_config_pkg.sv
// -----------------------------------------------------------------------------
// len5_config_pkg
//
// Shared configuration for the fetch-side memory responder.
//   FETCH_MEM_LATENCY    : request-to-response latency in cycles (>= 1)
//   FETCH_MEM_FIFO_DEPTH : response FIFO entries (power of 2, >= latency)
//   FETCH_MEM_WORDS      : instruction array size in 32-bit words (power of 2)
//   fetch_mem_resp_t     : one response beat {addr, data, err}. It is used both
//                          for the latency pipeline stages and the FIFO entries.
//   fetch_mem_out_of_range() : true when a byte address lies past the array.
// -----------------------------------------------------------------------------
package len5_config_pkg;

    localparam int unsigned FETCH_MEM_ADDR_W     = 64;
    localparam int unsigned FETCH_MEM_DATA_W     = 32;
    localparam int unsigned FETCH_MEM_LATENCY    = 2;
    localparam int unsigned FETCH_MEM_FIFO_DEPTH = 4;
    localparam int unsigned FETCH_MEM_WORDS      = 4096;

    typedef struct packed {
        logic [FETCH_MEM_ADDR_W-1:0] addr;
        logic [FETCH_MEM_DATA_W-1:0] data;
        logic                        err;
    } fetch_mem_resp_t;

    // The array covers byte addresses [0, words*4).
    function automatic logic fetch_mem_out_of_range(
        input logic [FETCH_MEM_ADDR_W-1:0] addr,
        input int unsigned                 words
    );
        return addr >= (FETCH_MEM_ADDR_W'(words) << 2);
    endfunction

endpackage : len5_config_pkg

// File: rtl/fetch_resp_fifo.sv
// -----------------------------------------------------------------------------
// fetch_resp_fifo
//
// In-order response FIFO with a synchronous flush. The head entry is read
// straight out of the storage registers, so every consumer-visible field is
// registered.
//
// Parameters:
//   entry_t : entry type (defaults to fetch_mem_resp_t)
//   DEPTH   : number of entries
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : clears pointers and count at the next edge; it wins over push/pop
//   push_i        : write push_data_i at the tail (ignored when full without pop)
//   push_data_i   : entry to enqueue
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry
//   empty_o       : no entries held
//   count_o       : current occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module fetch_resp_fifo
    import len5_config_pkg::*;
#(
    parameter type         entry_t = fetch_mem_resp_t,
    parameter int unsigned DEPTH   = FETCH_MEM_FIFO_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    output entry_t                       head_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t          storage_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            full;
    logic            do_push;
    logic            do_pop;

    // Explicit wrap keeps pointer arithmetic correct for any depth.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);
    assign head_o  = storage_q[rd_ptr_q];
    assign count_o = count_q;

    // NOTE: the storage is reset so the registered head (and therefore the
    // response outputs) reads as zero after reset; large RAM-style arrays
    // elsewhere are deliberately left without reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage_q[i] <= '0;
            end
        end else if (do_push) begin
            storage_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;   // idle, or push and pop together
            endcase
        end
    end

endmodule : fetch_resp_fifo

// File: rtl/fetch_mem_responder.sv
// -----------------------------------------------------------------------------
// fetch_mem_responder
//
// Instruction memory for the fetch unit. The block accepts PC requests on a
// valid/ready handshake and reads the addressed word from an internal array.
// The word then passes through LATENCY-1 register stages and is returned from
// an in-order response FIFO. The request side only accepts when a FIFO slot is
// guaranteed (credit = in-flight stages + FIFO occupancy), so the pipeline
// never has to stall.
//
// Parameters: LATENCY (>=1), FIFO_DEPTH (pow2, >= LATENCY), WORDS (pow2).
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   flush_i                  : drop everything in flight and queued
//   req_valid_i/req_ready_o  : request handshake
//   req_addr_i               : fetch byte address (PC)
//   resp_valid_o/resp_ready_i: response handshake
//   resp_addr_o              : echoed request address
//   resp_data_o              : instruction word (0 on error)
//   resp_err_o               : access fault
//   wr_en_i/wr_addr_i/wr_data_i : preload port (word-indexed)
//
// Build option: define FETCH_MEM_RESP_ALIGN_CHECK_EN to flag requests whose
// address is not word-aligned as errors. Without it, address bits [1:0] are
// ignored.
// -----------------------------------------------------------------------------
module fetch_mem_responder
    import len5_config_pkg::*;
#(
    parameter int unsigned LATENCY    = FETCH_MEM_LATENCY,
    parameter int unsigned FIFO_DEPTH = FETCH_MEM_FIFO_DEPTH,
    parameter int unsigned WORDS      = FETCH_MEM_WORDS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [63:0]                req_addr_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [63:0]                resp_addr_o,
    output logic [31:0]                resp_data_o,
    output logic                       resp_err_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(WORDS)-1:0]   wr_addr_i,
    input  logic [31:0]                wr_data_i
);

    localparam int unsigned AW = $clog2(WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    // Wide enough for the worst-case outstanding count (LATENCY-1 + FIFO_DEPTH).
    localparam int unsigned OW = $clog2(LATENCY + FIFO_DEPTH);

    // ---------------------------------------------------------------------
    // Instruction array (no reset: contents survive reset by design)
    // ---------------------------------------------------------------------
    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // ---------------------------------------------------------------------
    // Request decode. The array read is combinational and is captured at the
    // accepting edge, so a same-cycle preload write is not yet visible.
    // ---------------------------------------------------------------------
    fetch_mem_resp_t req_entry;
    logic            req_err;
    logic [AW-1:0]   req_word;
    logic            req_fire;

    assign req_word = req_addr_i[AW+1:2];
    assign req_fire = req_valid_i && req_ready_o;

    // NOTE: every variable assigned in an always_comb gets a value on every
    // path (defaults first) so no latch is inferred.
    always_comb begin
        req_err = fetch_mem_out_of_range(req_addr_i, WORDS);
`ifdef FETCH_MEM_RESP_ALIGN_CHECK_EN
        req_err = req_err | (req_addr_i[1:0] != 2'b00);
`endif
        req_entry.addr = req_addr_i;
        req_entry.err  = req_err;
        req_entry.data = req_err ? '0 : mem_q[req_word];
    end

    // ---------------------------------------------------------------------
    // Latency pipeline: LATENCY-1 stages feeding the FIFO
    // ---------------------------------------------------------------------
    logic            fifo_push;
    fetch_mem_resp_t fifo_push_data;
    logic [OW-1:0]   inflight;

    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign fifo_push      = req_fire;
            assign fifo_push_data = req_entry;
            assign inflight       = '0;
        end else begin : g_pipe
            localparam int unsigned NSTG = LATENCY - 1;

            logic [NSTG-1:0] stg_valid_q;
            fetch_mem_resp_t stg_q [NSTG];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stg_valid_q <= '0;
                    for (int i = 0; i < int'(NSTG); i++) begin
                        stg_q[i] <= '0;
                    end
                end else begin
                    // Flush only kills the valid bits; stale payload is harmless.
                    stg_valid_q[0] <= req_fire && !flush_i;
                    stg_q[0]       <= req_entry;
                    for (int i = 1; i < int'(NSTG); i++) begin
                        stg_valid_q[i] <= stg_valid_q[i-1] && !flush_i;
                        stg_q[i]       <= stg_q[i-1];
                    end
                end
            end

            always_comb begin
                inflight = '0;
                for (int i = 0; i < int'(NSTG); i++) begin
                    inflight = inflight + OW'(stg_valid_q[i]);
                end
            end

            assign fifo_push      = stg_valid_q[NSTG-1];
            assign fifo_push_data = stg_q[NSTG-1];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Response FIFO
    // ---------------------------------------------------------------------
    fetch_mem_resp_t fifo_head;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_pop;

    fetch_resp_fifo #(
        .entry_t (fetch_mem_resp_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // ---------------------------------------------------------------------
    // Handshakes. The credit ignores a same-cycle pop, so req_ready_o depends
    // only on registered state and flush_i, never on resp_ready_i.
    // ---------------------------------------------------------------------
    logic [OW-1:0] outstanding;

    assign outstanding  = inflight + OW'(fifo_count);
    assign req_ready_o  = !flush_i && (outstanding < OW'(FIFO_DEPTH));
    assign resp_valid_o = !fifo_empty && !flush_i;
    assign fifo_pop     = resp_valid_o && resp_ready_i;

    assign resp_addr_o  = fifo_head.addr;
    assign resp_data_o  = fifo_head.data;
    assign resp_err_o   = fifo_head.err;

endmodule : fetch_mem_responder

// File: tb/tb_fetch_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_fetch_mem_responder
//
// Scoreboard bench. The driver records every accepted request as an expected
// response. The expected response is computed from a word-array model and
// tagged with its acceptance cycle. A separate monitor checks each cycle:
// ready (the outstanding responses must fit in the FIFO), valid (the oldest
// response becomes visible exactly LATENCY cycles after its acceptance, unless
// flushed), and the payload of every consumed response.
// Inputs change at posedge+1. The monitor samples at negedge, and the driver
// updates the model at negedge+1.
// -----------------------------------------------------------------------------
module tb_fetch_mem_responder;

    localparam int unsigned LATENCY       = 2;
    localparam int unsigned FIFO_DEPTH    = 4;
    localparam int unsigned WORDS         = 4096;
    localparam int unsigned AW            = $clog2(WORDS);
    localparam int unsigned PRELOAD_WORDS = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [63:0]   req_addr_i = '0;
    logic          resp_valid_o;
    logic          resp_ready_i = 1'b0;
    logic [63:0]   resp_addr_o;
    logic [31:0]   resp_data_o;
    logic          resp_err_o;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [31:0]   wr_data_i = '0;

    fetch_mem_responder #(
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH),
        .WORDS      (WORDS)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_addr_o  (resp_addr_o),
        .resp_data_o  (resp_data_o),
        .resp_err_o   (resp_err_o),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [WORDS];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: byte address -> word, with range/alignment faults.
    function automatic exp_t model(input logic [63:0] addr, input int acc);
        exp_t e;
        e.addr = addr;
        e.acc  = acc;
        e.err  = (addr >= 64'(WORDS) * 4);
`ifdef FETCH_MEM_RESP_ALIGN_CHECK_EN
        if (addr % 4 != 0) e.err = 1'b1;
`endif
        e.data = e.err ? 32'h0 : ref_mem[int'(addr / 4)];
        return e;
    endfunction

    // Monitor: compares DUT outputs against the scoreboard every cycle.
    always @(negedge clk_i) begin
        logic exp_valid;
        exp_t e;
        exp_valid = 1'b0;
        if (!flush_i && sb.size() > 0) begin
            exp_valid = (cyc - sb[0].acc) >= int'(LATENCY);
        end
        check("req_ready", 64'(req_ready_o), 64'(!flush_i && sb.size() < int'(FIFO_DEPTH)));
        check("resp_valid", 64'(resp_valid_o), 64'(exp_valid));
        if (exp_valid && resp_ready_i) begin
            e = sb.pop_front();
            check("resp_addr", resp_addr_o, e.addr);
            check("resp_data", 64'(resp_data_o), 64'(e.data));
            check("resp_err", 64'(resp_err_o), 64'(e.err));
        end
    end

    // Advance one cycle, recording this cycle's handshake, flush and preload.
    task automatic tick(output bit accepted);
        @(negedge clk_i);
        #1;
        accepted = req_valid_i && req_ready_o;
        if (accepted) sb.push_back(model(req_addr_i, cyc));
        if (flush_i) sb.delete();
        if (wr_en_i) ref_mem[wr_addr_i] = wr_data_i;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) tick(a);
    endtask

    task automatic issue_one(input logic [63:0] addr);
        bit acc;
        int n = 0;
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        do begin
            tick(acc);
            n++;
        end while (!acc && n < 20);
        req_valid_i = 1'b0;
        check("issue_accept", 64'(acc), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = 32'h0;

        // Reset values.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_addr", resp_addr_o, 64'd0);
        check("rst_resp_data", 64'(resp_data_o), 64'd0);
        check("rst_resp_err", 64'(resp_err_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("rst_req_ready", 64'(req_ready_o), 64'd1);

        // Preload the low words; word 5 holds addi x1,x0,10.
        for (int w = 0; w < int'(PRELOAD_WORDS); w++) begin
            wr_en_i   = 1'b1;
            wr_addr_i = AW'(w);
            wr_data_i = (w == 5) ? 32'h00A0_0093 : $urandom;
            tick(acc);
        end
        wr_en_i = 1'b0;

        // Basic read with latency.
        resp_ready_i = 1'b1;
        issue_one(64'h14);
        idle(LATENCY + 2);

        // Credit limit under backpressure.
        resp_ready_i = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 64'(n * 4);
            tick(acc);
            if (acc) n++;
        end
        req_valid_i = 1'b0;
        check("credit_accepts", 64'(n), 64'(FIFO_DEPTH));
        check("credit_ready_low", 64'(req_ready_o), 64'd0);
        resp_ready_i = 1'b1;
        idle(8);

        // Out-of-range and unaligned accesses.
        issue_one(64'h4000);
        issue_one(64'h6);
        issue_one(64'hFFFF_FFFF_FFFF_FFFC);
        idle(LATENCY + 2);

        // Flush with three queued and one in flight.
        resp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = 64'(16 + 4 * i);
            tick(acc);
            check("flush_fill_accept", 64'(acc), 64'd1);
        end
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        #1;
        check("flush_resp_valid", 64'(resp_valid_o), 64'd0);
        check("flush_req_ready", 64'(req_ready_o), 64'd0);
        tick(acc);
        flush_i      = 1'b0;
        resp_ready_i = 1'b1;
        idle(4);
        issue_one(64'h8);
        idle(LATENCY + 2);

        // Read-before-write on the same word in the same cycle.
        req_valid_i = 1'b1;
        req_addr_i  = 64'h1C;
        wr_en_i     = 1'b1;
        wr_addr_i   = AW'(7);
        wr_data_i   = 32'hDEAD_BEEF;
        tick(acc);
        check("rbw_accept", 64'(acc), 64'd1);
        req_valid_i = 1'b0;
        wr_en_i     = 1'b0;
        issue_one(64'h1C);
        idle(LATENCY + 2);

        // Asynchronous reset with two queued responses.
        resp_ready_i = 1'b0;
        issue_one(64'h0);
        issue_one(64'h4);
        idle(3);
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("midrst_resp_data", 64'(resp_data_o), 64'd0);
        idle(2);
        rst_ni = 1'b1;
        #1;
        check("postrst_req_ready", 64'(req_ready_o), 64'd1);
        resp_ready_i = 1'b1;
        issue_one(64'h14);
        issue_one(64'h1C);
        idle(LATENCY + 2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(99);
            req_valid_i = ($urandom_range(3) != 0);
            if (r < 10)
                req_addr_i = {$urandom, $urandom} | 64'h1_0000_0000;
            else if (r < 20)
                req_addr_i = 64'($urandom_range(PRELOAD_WORDS - 1) * 4 + $urandom_range(3, 1));
            else
                req_addr_i = 64'($urandom_range(PRELOAD_WORDS - 1) * 4);
            resp_ready_i = ($urandom_range(3) != 0);
            flush_i      = ($urandom_range(99) < 3);
            wr_en_i      = ($urandom_range(4) == 0);
            wr_addr_i    = AW'($urandom_range(PRELOAD_WORDS - 1));
            wr_data_i    = $urandom;
            tick(acc);
        end

        // Drain.
        req_valid_i  = 1'b0;
        flush_i      = 1'b0;
        wr_en_i      = 1'b0;
        resp_ready_i = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            tick(acc);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fetch_mem_responder
